// File: rtl/display_arbiter.sv
// display_arbiter: shares the 4-digit multiplexed 7-segment display between the
// four service datapaths and the idle current-time source. It scans the digits,
// blinks the edit cursor and forces every segment on while the alarm flashes.
// Ownership changes only when digit 3 wraps back to digit 0, so one frame never
// mixes digits from two sources.
module display_arbiter #(
  parameter int SCAN_DIV_W  = 16,
  parameter int BLINK_DIV_W = 25
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] data_s1,
  input  logic [15:0] data_s2,
  input  logic [15:0] data_s3,
  input  logic [15:0] data_s4,
  input  logic [15:0] idle_data,
  input  logic [3:0]  cursor_s1,
  input  logic [3:0]  cursor_s2,
  input  logic        alarm_flash,
  output logic [3:0]  grant,
  output logic        frame_start,
  output logic [3:0]  anode,
  output logic [6:0]  seg
);

  logic [SCAN_DIV_W-1:0]  scan_cnt;
  logic [BLINK_DIV_W-1:0] blink_cnt;
  logic [1:0]             idx;
  logic                   tick;
  logic                   wrap;
  logic [3:0]             next_grant;
  logic [15:0]            src;
  logic [3:0]             nibble;
  logic [6:0]             seg_dec;
  logic                   blink_phase;
  logic                   blank_digit;
  logic                   flash_on;

  assign tick        = &scan_cnt;
  assign wrap        = tick && (idx == 2'd3);
  assign blink_phase = blink_cnt[BLINK_DIV_W-1];

  // Fixed-priority pick of the next owner: svc1 beats svc2 beats svc3 beats svc4.
  always_comb begin
    next_grant = 4'b0000;
    if (req[3])      next_grant = 4'b1000;
    else if (req[2]) next_grant = 4'b0100;
    else if (req[1]) next_grant = 4'b0010;
    else if (req[0]) next_grant = 4'b0001;
  end

  // Select the owner's digits and the nibble for the digit currently being scanned.
  always_comb begin
    case (grant)
      4'b1000: src = data_s1;
      4'b0100: src = data_s2;
      4'b0010: src = data_s3;
      4'b0001: src = data_s4;
      default: src = idle_data;
    endcase
    nibble = src[{idx, 2'b00} +: 4];
  end

  // BCD to active-low {g..a}; non-decimal codes show a dark digit.
  always_comb begin
    case (nibble)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // Cursor blink only applies to the two editing services; flash only to svc4 or idle.
  always_comb begin
    blank_digit = blink_phase &&
                  (((grant == 4'b1000) && cursor_s1[idx]) ||
                   ((grant == 4'b0100) && cursor_s2[idx]));
    flash_on    = alarm_flash && ((grant == 4'b0001) || (grant == 4'b0000));
  end

  // Free-running dividers, digit scan position and frame-boundary ownership latch.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      idx         <= 2'd0;
      grant       <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      scan_cnt    <= scan_cnt + 1'b1;
      blink_cnt   <= blink_cnt + 1'b1;
      frame_start <= wrap;
      if (tick) idx <= idx + 2'd1;
      if (wrap) grant <= next_grant;
    end
  end

  // Register the pad drivers one cycle behind the scan position so they are glitch-free.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      anode <= 4'b1111;
      seg   <= 7'b1111111;
    end else begin
      anode <= blank_digit ? 4'b1111 : ~(4'b0001 << idx);
      seg   <= flash_on ? 7'b0000000 : seg_dec;
    end
  end

endmodule
